// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: UNROLL rounds per clock with the key schedule computed alongside.
// A finished block is held on Result until the consumer takes it; a new job may load in the same cycle.
module aes128_encrypt_iter #(
  parameter int UNROLL     = 1,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] Block,
  input  logic [127:0] Key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] Result,
  output logic         busy
);
  // state | meaning
  // IDLE  | no job, accepting
  // RUN   | applying UNROLL rounds per clock
  // DONE  | ciphertext on Result, waiting for out_ready

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
    $error("aes128_encrypt_iter: UNROLL must be 1, 2, 5 or 10");
  end

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    case (r)
      4'd1:  v = 8'h01;
      4'd2:  v = 8'h02;
      4'd3:  v = 8'h04;
      4'd4:  v = 8'h08;
      4'd5:  v = 8'h10;
      4'd6:  v = 8'h20;
      4'd7:  v = 8'h40;
      4'd8:  v = 8'h80;
      4'd9:  v = 8'h1b;
      4'd10: v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = rk;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte k sits at [127-8k -: 8]; k = 4*column + row.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] m [16];
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) a[k] = sbox(s[127-8*k -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[4*c+r] = a[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      m[4*c]   = xtime(b[4*c]) ^ xtime(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
      m[4*c+1] = b[4*c] ^ xtime(b[4*c+1]) ^ xtime(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
      m[4*c+2] = b[4*c] ^ b[4*c+1] ^ xtime(b[4*c+2]) ^ xtime(b[4*c+3]) ^ b[4*c+3];
      m[4*c+3] = xtime(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xtime(b[4*c+3]);
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = last ? b[k] : m[k];
    return o ^ rk;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         st_q, st_d;
  logic [127:0] state_q, rkey_q;
  logic [3:0]   rnd_q;
  logic [3:0]   rnd_last;
  logic         load;
  logic [127:0] st_next, rk_next;

  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
    logic [127:0] st_i, rk_i, st_o, rk_o;
    logic [3:0]   r;
    if (gi == 0) begin : g_first
      assign st_i = state_q;
      assign rk_i = rkey_q;
    end else begin : g_chain
      assign st_i = g_round[gi-1].st_o;
      assign rk_i = g_round[gi-1].rk_o;
    end
    assign r    = rnd_q + 4'(gi);
    assign rk_o = key_expand(rk_i, rcon(r));
    assign st_o = aes_round(st_i, rk_o, r == 4'd10);
  end

  assign st_next  = g_round[UNROLL-1].st_o;
  assign rk_next  = g_round[UNROLL-1].rk_o;
  assign rnd_last = rnd_q + 4'(UNROLL - 1);

  always_comb begin
    st_d      = st_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    case (st_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load = 1'b1;
          st_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (rnd_last == 4'd10) st_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            load = 1'b1;
            st_d = RUN;
          end else begin
            st_d = IDLE;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= IDLE;
      state_q <= '0;
      rkey_q  <= '0;
      rnd_q   <= '0;
    end else begin
      st_q <= st_d;
      if (load) begin
        state_q <= Block ^ Key;
        rkey_q  <= Key;
        rnd_q   <= 4'd1;
      end else if (st_q == RUN) begin
        state_q <= st_next;
        rkey_q  <= rk_next;
        rnd_q   <= rnd_q + 4'(UNROLL);
      end
    end
  end

  assign Result = (CLEAR_DATA && !out_valid) ? '0 : state_q;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Directed bench for aes128_encrypt_iter: one instance per legal UNROLL, known-answer vectors,
// latency, output hold, back-to-back streaming and mid-job reset.
module tb_aes128_encrypt_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   reset, in_valid, out_ready;
  wire  [3:0]   in_ready, out_valid, busy;
  logic [127:0] block [4];
  logic [127:0] key   [4];
  wire  [127:0] result [4];

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K3 = 128'h0;
  localparam logic [127:0] B3 = 128'h0;
  localparam logic [127:0] C3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int U = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    aes128_encrypt_iter #(.UNROLL(U), .CLEAR_DATA(1'b1)) dut (
      .clk       (clk),
      .reset     (reset[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .Block     (block[g]),
      .Key       (key[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .Result    (result[g]),
      .busy      (busy[g])
    );
  end

  function automatic int unr(input int u);
    return (u == 0) ? 1 : (u == 1) ? 2 : (u == 2) ? 5 : 10;
  endfunction

  function automatic int lat(input int u);
    return 10 / unr(u) + 1;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic string tg(input int u, input string name);
    return $sformatf("u%0d_%s", unr(u), name);
  endfunction

  // Present one job, then wait (bounded) for out_valid; latency counts edges from the accept edge.
  task automatic run_job(input int u, input logic [127:0] k, input logic [127:0] b,
                         input logic [127:0] exp, input string name);
    int n;
    check(tg(u, {name, "_in_ready"}), 128'(in_ready[u]), 128'(1'b1));
    key[u] = k; block[u] = b; in_valid[u] = 1'b1;
    tick();
    n = 1;
    in_valid[u] = 1'b0;
    key[u] = '1; block[u] = '1;
    check(tg(u, {name, "_busy"}), 128'(busy[u]), 128'(1'b1));
    check(tg(u, {name, "_clear"}), result[u], 128'h0);
    while (!out_valid[u] && n < 30) begin
      tick();
      n++;
    end
    check(tg(u, {name, "_latency"}), 128'(n), 128'(lat(u)));
    check(tg(u, {name, "_result"}), result[u], exp);
  endtask

  task automatic test_unroll(input int u);
    logic [127:0] vk [3];
    logic [127:0] vb [3];
    logic [127:0] vc [3];
    int n, got, rc;
    vk = '{K1, K2, K3}; vb = '{B1, B2, B3}; vc = '{C1, C2, C3};

    // known answers
    out_ready[u] = 1'b1;
    run_job(u, K1, B1, C1, "v1");
    tick();
    run_job(u, K2, B2, C2, "v2");
    tick();

    // all-zero vector with the consumer stalling; a new request must be ignored
    out_ready[u] = 1'b0;
    run_job(u, K3, B3, C3, "v3");
    for (int i = 0; i < 5; i++) begin
      key[u] = K1; block[u] = B1; in_valid[u] = 1'b1;
      tick();
      check(tg(u, $sformatf("hold%0d_valid", i)), 128'(out_valid[u]), 128'(1'b1));
      check(tg(u, $sformatf("hold%0d_result", i)), result[u], C3);
      check(tg(u, $sformatf("hold%0d_in_ready", i)), 128'(in_ready[u]), 128'(1'b0));
    end
    in_valid[u] = 1'b0;
    out_ready[u] = 1'b1;
    tick();
    check(tg(u, "drain_valid"), 128'(out_valid[u]), 128'(1'b0));
    check(tg(u, "drain_in_ready"), 128'(in_ready[u]), 128'(1'b1));

    // back-to-back stream with in_valid held high
    key[u] = vk[0]; block[u] = vb[0]; in_valid[u] = 1'b1;
    n = 0; got = 0;
    while (got < 3 && n < 200) begin
      tick();
      n++;
      if (out_valid[u]) begin
        check(tg(u, $sformatf("stream%0d_result", got)), result[u], vc[got]);
        check(tg(u, $sformatf("stream%0d_cycle", got)), 128'(n), 128'((got + 1) * lat(u)));
        got++;
        if (got < 3) begin
          key[u] = vk[got]; block[u] = vb[got];
        end else begin
          in_valid[u] = 1'b0;
        end
      end
    end
    check(tg(u, "stream_count"), 128'(got), 128'(3));
    tick();

    // reset during RUN cycle 4 (or the last RUN cycle when there are fewer)
    rc = (lat(u) - 1 < 4) ? lat(u) - 1 : 4;
    key[u] = K2; block[u] = B2; in_valid[u] = 1'b1;
    tick();
    in_valid[u] = 1'b0;
    for (int i = 1; i < rc; i++) tick();
    check(tg(u, "pre_reset_busy"), 128'(busy[u]), 128'(1'b1));
    reset[u] = 1'b1;
    tick();
    reset[u] = 1'b0;
    check(tg(u, "rst_in_ready"), 128'(in_ready[u]), 128'(1'b1));
    check(tg(u, "rst_out_valid"), 128'(out_valid[u]), 128'(1'b0));
    check(tg(u, "rst_busy"), 128'(busy[u]), 128'(1'b0));
    check(tg(u, "rst_result"), result[u], 128'h0);
    run_job(u, K1, B1, C1, "post_rst");
    tick();
  endtask

  initial begin
    reset = 4'hf; in_valid = 4'h0; out_ready = 4'hf;
    for (int u = 0; u < 4; u++) begin
      block[u] = '0;
      key[u]   = '0;
    end
    tick();
    tick();
    reset = 4'h0;
    for (int u = 0; u < 4; u++) begin
      check(tg(u, "init_in_ready"), 128'(in_ready[u]), 128'(1'b1));
      check(tg(u, "init_out_valid"), 128'(out_valid[u]), 128'(1'b0));
      check(tg(u, "init_busy"), 128'(busy[u]), 128'(1'b0));
      check(tg(u, "init_result"), result[u], 128'h0);
    end
    for (int u = 0; u < 4; u++) test_unroll(u);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
